mips_fetch_unit: RTL

Parametrised instruction-fetch stage for the next-generation MIPS core. It replaces the single-cycle PC-plus-direct-memory fetch with a decoupled, pipelined fetch.
- Issues in-order requests to an instruction memory over a valid/ready handshake, with multiple requests in flight.
- Buffers returned words in a prefetch queue and presents {pc, instr} to decode over valid/ready.
- Handles branch/jump redirects by flushing the queue and dropping stale in-flight responses.

---
 rtl/mips_fetch_unit.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit: decoupled, pipelined instruction fetch with prefetch queue.
// Optional FETCH_HALT_EN: stop fetching after a null (all-zero) instruction.
module mips_fetch_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH = 4,
  parameter int PC_STEP = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              halted
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] CAP = CW'(DEPTH);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
`ifdef FETCH_HALT_EN
  localparam logic [1:0] S_HALT  = 2'd3;
`endif

  logic [1:0]        state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] rsp_pc;
  logic [CW-1:0]     occ;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     drop_cnt;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [ADDR_W-1:0] q_pc    [DEPTH];
  logic [DATA_W-1:0] q_instr [DEPTH];

  logic          issue_ok;
  logic          req_fire;
  logic          drop;
  logic          push;
  logic          pop;
  logic          null_push;
  logic [CW-1:0] outstanding_nx;
  logic [CW-1:0] drop_nx;

  assign if_valid  = (occ != '0);
  assign if_pc     = if_valid ? q_pc[rd_ptr] : '0;
  assign if_instr  = if_valid ? q_instr[rd_ptr] : '0;
  assign imem_addr = fetch_pc;

  always_comb begin
    issue_ok = (state == S_FETCH) || (state == S_FLUSH);
    // occ + outstanding never exceeds DEPTH, so CW bits suffice
    imem_req_valid = issue_ok && !redirect_valid &&
                     ((occ + outstanding) < CAP);
    req_fire = imem_req_valid && imem_req_ready;
    drop = imem_rsp_valid &&
           ((drop_cnt != '0) || redirect_valid);
    push = imem_rsp_valid && !drop;
    pop  = if_valid && if_ready;
    outstanding_nx = outstanding + CW'(req_fire)
                     - CW'(imem_rsp_valid);
`ifdef FETCH_HALT_EN
    null_push = push && (imem_rsp_data == '0);
`else
    null_push = 1'b0;
`endif
    if (redirect_valid || null_push) begin
      drop_nx = outstanding_nx;
    end else begin
      drop_nx = drop_cnt - CW'(drop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]    <= rsp_pc;
      q_instr[wr_ptr] <= imem_rsp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      occ         <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      outstanding <= outstanding_nx;
      drop_cnt    <= drop_nx;
      if (redirect_valid) begin
        fetch_pc <= redirect_addr;
        rsp_pc   <= redirect_addr;
        occ      <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        state    <= (drop_nx != '0) ? S_FLUSH : S_FETCH;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + STEP;
        if (push) begin
          rsp_pc <= rsp_pc + STEP;
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        occ <= occ + CW'(push) - CW'(pop);
        if (null_push) begin
`ifdef FETCH_HALT_EN
          state <= S_HALT;
`endif
        end else begin
          case (state)
            S_IDLE:  state <= S_FETCH;
            S_FLUSH: if (drop_nx == '0) state <= S_FETCH;
            default: ;
          endcase
        end
      end
    end
  end

`ifdef FETCH_HALT_EN
  logic halt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      halt_q <= 1'b0;
    end else if (redirect_valid) begin
      halt_q <= 1'b0;
    end else if (null_push) begin
      halt_q <= 1'b1;
    end
  end

  assign halted = halt_q;
`else
  assign halted = 1'b0;
`endif

endmodule
